bp_fe_ltb_update_sched: RTL and testbench
=========================================

BP_FE_LTB_UPDATE_SCHED -- requirements
Module: bp_fe_ltb_update_sched

Interface
REQ-001 Parameters SHALL be:
- vaddr_width_p, default 39, branch source address width.
- ltb_cnt_width_p, default 8, loop counter width.
- fifo_els_p, default 4, commit update queue depth (power of 2, >=2).
- starve_lim_p, default 4, maximum consecutive redirect grants while the queue is non-empty.

REQ-002 The block SHALL use one clock and a synchronous active-low reset. Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- ltb_init_done_i  in  1  LTB table initialization complete.
- redirect_v_i  in  1  mispredict-time update valid.
- redirect_ready_o  out  1  redirect accepted when high with redirect_v_i.
- redirect_taken_i, redirect_conf_i  in  1 each  update payload.
- redirect_src_addr_i  in  vaddr_width_p  update payload.
- redirect_non_spec_cnt_i, redirect_trip_cnt_i  in  ltb_cnt_width_p  update payload.
- commit_v_i  in  1  commit-time update valid.
- commit_ready_o  out  1  commit accepted when high with commit_v_i.
- commit_taken_i, commit_conf_i, commit_src_addr_i, commit_non_spec_cnt_i, commit_trip_cnt_i  in  as redirect fields  commit payload.
- flush_i  in  1  discard all queued commit updates.
- ltb_w_v_o  out  1  LTB write request valid.
- ltb_br_mispredict_o, ltb_br_taken_o, ltb_br_conf_o  out  1 each  write payload.
- ltb_br_src_addr_o  out  vaddr_width_p  write payload.
- ltb_br_non_spec_cnt_o, ltb_br_trip_cnt_o  out  ltb_cnt_width_p  write payload.
- ltb_w_yumi_i  in  1  LTB consumed the write this cycle.
- queue_cnt_o  out  $clog2(fifo_els_p+1)  commit queue occupancy.
- busy_o  out  1  queue non-empty or ltb_w_v_o high.

Function
REQ-003 The FSM SHALL have two states: e_wait_init and e_run. Reset enters e_wait_init. The FSM moves to e_run the cycle after ltb_init_done_i=1 and stays there until reset.
REQ-004 In e_wait_init, redirect_ready_o, commit_ready_o and ltb_w_v_o SHALL all be 0.
REQ-005 The output register (out_v_r plus payload) SHALL be "free" when out_v_r=0 or ltb_w_yumi_i=1 in that cycle.
REQ-006 While out_v_r=1 and ltb_w_yumi_i=0, the ltb_* payload SHALL hold stable.
REQ-007 redirect_ready_o SHALL equal e_run & free & ~force_q. force_q = (starve_cnt == starve_lim_p) & queue non-empty.
REQ-008 Load priority when the output register is free:
- redirect_v_i & redirect_ready_o: load the redirect payload with ltb_br_mispredict_o=1.
- otherwise, queue non-empty: pop the queue head and load it with ltb_br_mispredict_o=0.
- otherwise: out_v_r clears.
REQ-009 starve_cnt SHALL increment on each redirect load while the queue is non-empty, saturating at starve_lim_p. It SHALL clear on any queue pop or when the queue is empty.
REQ-010 commit_ready_o SHALL equal e_run & ~flush_i & (queue not full | pop this cycle). An accepted commit is written at the queue tail.
REQ-011 The queue SHALL be FIFO ordered with no bypass. Minimum commit-to-ltb_w_v_o latency is 2 cycles. Redirect-to-ltb_w_v_o latency is 1 cycle.
REQ-012 Pointers SHALL wrap modulo fifo_els_p. Push and pop in the same cycle leave occupancy unchanged, including when the queue is full.
REQ-013 flush_i=1 SHALL empty the queue at the next edge and discard any same-cycle push. It does not pop for output and does not affect out_v_r or a held payload.
REQ-014 queue_cnt_o SHALL always equal pushes minus pops minus flushed entries, in the range 0..fifo_els_p.
REQ-015 ltb_w_v_o SHALL equal out_v_r. ltb_w_yumi_i while out_v_r=0 is ignored.

Reset
REQ-016 With reset_n_i=0 at an edge, the following SHALL clear: state=e_wait_init, out_v_r=0, queue pointers and count=0, starve_cnt=0. This holds mid-operation and discards queued and held updates.
REQ-017 After reset all outputs SHALL read 0: ltb_w_v_o, both ready outputs, queue_cnt_o, busy_o and all ltb_* payload fields.

Verification
REQ-018 Hold ltb_init_done_i=0 for 10 cycles with both valids high -> both readies stay 0 and ltb_w_v_o stays 0. Raise init_done -> readies go high the next cycle.
REQ-019 Redirect with addr 0x1000 and taken=0, ltb_w_yumi_i=1 -> next cycle ltb_w_v_o=1, src_addr=0x1000, mispredict=1.
REQ-020 Push 4 commits with ltb_w_yumi_i=0 -> queue_cnt_o=4 and commit_ready_o=0. Assert yumi -> writes emerge in push order, one per cycle.
REQ-021 Queue holds 2 entries, redirect_v_i high every cycle, yumi always 1 -> 4 redirect writes, then 1 commit write, then redirects resume.
REQ-022 Queue holds 3 entries, out_v_r held unconsumed, flush_i plus commit_v_i in the same cycle -> queue_cnt_o=0 next cycle and the held payload is unchanged.
REQ-023 Reset asserted with a full queue and out_v_r=1 -> next cycle all outputs are 0 and the FSM is in e_wait_init.

Source files
------------

// File: rtl/bp_fe_ltb_update_sched.sv
// rtl/bp_fe_ltb_update_sched.sv - LTB write scheduler arbitrating redirect updates against a queue of commit updates
//
// Purpose: merges mispredict-time (redirect) and commit-time LTB updates into a
// single registered LTB write port. Redirects bypass the commit queue and take
// priority, but a starvation limiter forces a queue pop after starve_lim_p
// consecutive redirect writes while commits are waiting.
//
// Ports:
//   clk_i, reset_n_i         clock, synchronous active-low reset
//   ltb_init_done_i          LTB table initialised; scheduler starts accepting
//   redirect_*               redirect update valid/ready/payload
//   commit_*                 commit update valid/ready/payload (queued)
//   flush_i                  drop every queued commit update
//   ltb_w_v_o, ltb_br_*      registered LTB write request and payload
//   ltb_w_yumi_i             LTB consumed the current write
//   queue_cnt_o, busy_o      commit queue occupancy, activity indication
module bp_fe_ltb_update_sched #(
    parameter int vaddr_width_p   = 39,
    parameter int ltb_cnt_width_p = 8,
    parameter int fifo_els_p      = 4,
    parameter int starve_lim_p    = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         ltb_init_done_i,

    input  logic                         redirect_v_i,
    output logic                         redirect_ready_o,
    input  logic                         redirect_taken_i,
    input  logic                         redirect_conf_i,
    input  logic [vaddr_width_p-1:0]     redirect_src_addr_i,
    input  logic [ltb_cnt_width_p-1:0]   redirect_non_spec_cnt_i,
    input  logic [ltb_cnt_width_p-1:0]   redirect_trip_cnt_i,

    input  logic                         commit_v_i,
    output logic                         commit_ready_o,
    input  logic                         commit_taken_i,
    input  logic                         commit_conf_i,
    input  logic [vaddr_width_p-1:0]     commit_src_addr_i,
    input  logic [ltb_cnt_width_p-1:0]   commit_non_spec_cnt_i,
    input  logic [ltb_cnt_width_p-1:0]   commit_trip_cnt_i,

    input  logic                         flush_i,

    output logic                         ltb_w_v_o,
    output logic                         ltb_br_mispredict_o,
    output logic                         ltb_br_taken_o,
    output logic                         ltb_br_conf_o,
    output logic [vaddr_width_p-1:0]     ltb_br_src_addr_o,
    output logic [ltb_cnt_width_p-1:0]   ltb_br_non_spec_cnt_o,
    output logic [ltb_cnt_width_p-1:0]   ltb_br_trip_cnt_o,
    input  logic                         ltb_w_yumi_i,

    output logic [$clog2(fifo_els_p+1)-1:0] queue_cnt_o,
    output logic                         busy_o
);

    localparam int ptr_w    = $clog2(fifo_els_p);
    localparam int cnt_w    = $clog2(fifo_els_p + 1);
    localparam int starve_w = $clog2(starve_lim_p + 1);

    localparam logic [cnt_w-1:0]    fifo_full_c   = cnt_w'(fifo_els_p);
    localparam logic [starve_w-1:0] starve_lim_c  = starve_w'(starve_lim_p);

    typedef enum logic {
        e_wait_init,
        e_run
    } state_e;

    typedef struct packed {
        logic                       taken;
        logic                       conf;
        logic [vaddr_width_p-1:0]   src_addr;
        logic [ltb_cnt_width_p-1:0] non_spec_cnt;
        logic [ltb_cnt_width_p-1:0] trip_cnt;
    } upd_s;

    state_e              state_q, state_d;
    logic                out_v_q, out_v_d;
    logic                out_mis_q, out_mis_d;
    upd_s                out_q, out_d;
    logic [ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]    cnt_q, cnt_d;
    logic [starve_w-1:0] starve_q, starve_d;
    upd_s                mem_q [fifo_els_p];

    logic run, free, q_empty, q_full, force_pop;
    logic redirect_ready, redirect_load, commit_ready, push, pop;
    upd_s redirect_upd, commit_upd;

    always_comb begin
        redirect_upd = '{taken: redirect_taken_i, conf: redirect_conf_i,
                         src_addr: redirect_src_addr_i,
                         non_spec_cnt: redirect_non_spec_cnt_i,
                         trip_cnt: redirect_trip_cnt_i};
        commit_upd   = '{taken: commit_taken_i, conf: commit_conf_i,
                         src_addr: commit_src_addr_i,
                         non_spec_cnt: commit_non_spec_cnt_i,
                         trip_cnt: commit_trip_cnt_i};

        state_d = state_q;
        if (state_q == e_wait_init && ltb_init_done_i) begin
            state_d = e_run;
        end

        run       = (state_q == e_run);
        // Output register can take new data if empty or being consumed now.
        free      = ~out_v_q | ltb_w_yumi_i;
        q_empty   = (cnt_q == '0);
        q_full    = (cnt_q == fifo_full_c);
        // Redirects have had their quota while commits waited: let a commit through.
        force_pop = (starve_q == starve_lim_c) & ~q_empty;

        redirect_ready = run & free & ~force_pop;
        redirect_load  = redirect_v_i & redirect_ready;
        pop            = free & ~redirect_load & ~q_empty;
        // A full queue can still accept when its head leaves in the same cycle.
        commit_ready   = run & ~flush_i & (~q_full | pop);
        push           = commit_v_i & commit_ready;

        out_v_d   = out_v_q;
        out_mis_d = out_mis_q;
        out_d     = out_q;
        if (redirect_load) begin
            out_v_d   = 1'b1;
            out_mis_d = 1'b1;
            out_d     = redirect_upd;
        end else if (pop) begin
            out_v_d   = 1'b1;
            out_mis_d = 1'b0;
            out_d     = mem_q[rd_ptr_q];
        end else if (free) begin
            out_v_d   = 1'b0;
        end

        starve_d = starve_q;
        if (pop || q_empty) begin
            starve_d = '0;
        end else if (redirect_load && starve_q != starve_lim_c) begin
            starve_d = starve_q + starve_w'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + ptr_w'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ptr_w'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + cnt_w'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - cnt_w'(1);
        end
        // Flush drops the queue; a head popped this cycle still reaches the output.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= e_wait_init;
            out_v_q   <= 1'b0;
            out_mis_q <= 1'b0;
            out_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            out_v_q   <= out_v_d;
            out_mis_q <= out_mis_d;
            out_q     <= out_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            if (push) begin
                mem_q[wr_ptr_q] <= commit_upd;
            end
        end
    end

    assign redirect_ready_o      = redirect_ready;
    assign commit_ready_o        = commit_ready;
    assign ltb_w_v_o             = out_v_q;
    assign ltb_br_mispredict_o   = out_mis_q;
    assign ltb_br_taken_o        = out_q.taken;
    assign ltb_br_conf_o         = out_q.conf;
    assign ltb_br_src_addr_o     = out_q.src_addr;
    assign ltb_br_non_spec_cnt_o = out_q.non_spec_cnt;
    assign ltb_br_trip_cnt_o     = out_q.trip_cnt;
    assign queue_cnt_o           = cnt_q;
    assign busy_o                = ~q_empty | out_v_q;

endmodule

// File: tb/tb_bp_fe_ltb_update_sched.sv
// tb/tb_bp_fe_ltb_update_sched.sv - self-checking bench for bp_fe_ltb_update_sched
module tb_bp_fe_ltb_update_sched;

    localparam int VA   = 39;
    localparam int CW   = 8;
    localparam int ELS  = 4;
    localparam int LIM  = 4;
    localparam int QCW  = $clog2(ELS + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n_i = 1'b0, ltb_init_done_i = 1'b0;
    logic redirect_v_i = 1'b0, redirect_ready_o, redirect_taken_i = 1'b0, redirect_conf_i = 1'b0;
    logic [VA-1:0] redirect_src_addr_i = '0;
    logic [CW-1:0] redirect_non_spec_cnt_i = '0, redirect_trip_cnt_i = '0;
    logic commit_v_i = 1'b0, commit_ready_o, commit_taken_i = 1'b0, commit_conf_i = 1'b0;
    logic [VA-1:0] commit_src_addr_i = '0;
    logic [CW-1:0] commit_non_spec_cnt_i = '0, commit_trip_cnt_i = '0;
    logic flush_i = 1'b0;
    logic ltb_w_v_o, ltb_br_mispredict_o, ltb_br_taken_o, ltb_br_conf_o;
    logic [VA-1:0] ltb_br_src_addr_o;
    logic [CW-1:0] ltb_br_non_spec_cnt_o, ltb_br_trip_cnt_o;
    logic ltb_w_yumi_i = 1'b0;
    logic [QCW-1:0] queue_cnt_o;
    logic busy_o;

    bp_fe_ltb_update_sched #(
        .vaddr_width_p(VA), .ltb_cnt_width_p(CW), .fifo_els_p(ELS), .starve_lim_p(LIM)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .ltb_init_done_i(ltb_init_done_i),
        .redirect_v_i(redirect_v_i), .redirect_ready_o(redirect_ready_o),
        .redirect_taken_i(redirect_taken_i), .redirect_conf_i(redirect_conf_i),
        .redirect_src_addr_i(redirect_src_addr_i),
        .redirect_non_spec_cnt_i(redirect_non_spec_cnt_i), .redirect_trip_cnt_i(redirect_trip_cnt_i),
        .commit_v_i(commit_v_i), .commit_ready_o(commit_ready_o),
        .commit_taken_i(commit_taken_i), .commit_conf_i(commit_conf_i),
        .commit_src_addr_i(commit_src_addr_i),
        .commit_non_spec_cnt_i(commit_non_spec_cnt_i), .commit_trip_cnt_i(commit_trip_cnt_i),
        .flush_i(flush_i),
        .ltb_w_v_o(ltb_w_v_o), .ltb_br_mispredict_o(ltb_br_mispredict_o),
        .ltb_br_taken_o(ltb_br_taken_o), .ltb_br_conf_o(ltb_br_conf_o),
        .ltb_br_src_addr_o(ltb_br_src_addr_o),
        .ltb_br_non_spec_cnt_o(ltb_br_non_spec_cnt_o), .ltb_br_trip_cnt_o(ltb_br_trip_cnt_o),
        .ltb_w_yumi_i(ltb_w_yumi_i),
        .queue_cnt_o(queue_cnt_o), .busy_o(busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending commits as a plain queue, output as one slot.
    bit              m_valid = 1'b0;
    bit              m_run   = 1'b0;
    bit              m_out_v = 1'b0;
    logic [57:0]     m_pay   = '0;
    logic [56:0]     m_q[$];
    int              m_starve = 0;

    function automatic logic [57:0] dut_pay();
        return {ltb_br_mispredict_o, ltb_br_taken_o, ltb_br_conf_o, ltb_br_src_addr_o,
                ltb_br_non_spec_cnt_o, ltb_br_trip_cnt_o};
    endfunction

    // Called at a negedge with inputs already driven; checks, steps one edge, returns at next negedge.
    task automatic cycle();
        bit free, frc, rr, cr, rl, pop, nonempty;
        logic [56:0] r_ent, c_ent;
        #1;
        nonempty = (m_q.size() != 0);
        free = !m_out_v || ltb_w_yumi_i;
        frc  = (m_starve == LIM) && nonempty;
        rr   = m_run && free && !frc;
        rl   = redirect_v_i && rr;
        pop  = free && !rl && nonempty;
        cr   = m_run && !flush_i && (m_q.size() < ELS || pop);
        r_ent = {redirect_taken_i, redirect_conf_i, redirect_src_addr_i,
                 redirect_non_spec_cnt_i, redirect_trip_cnt_i};
        c_ent = {commit_taken_i, commit_conf_i, commit_src_addr_i,
                 commit_non_spec_cnt_i, commit_trip_cnt_i};
        if (m_valid) begin
            chk("redirect_ready", 64'(redirect_ready_o), 64'(rr));
            chk("commit_ready", 64'(commit_ready_o), 64'(cr));
            chk("ltb_w_v", 64'(ltb_w_v_o), 64'(m_out_v));
            chk("queue_cnt", 64'(queue_cnt_o), 64'(m_q.size()));
            chk("busy", 64'(busy_o), 64'(m_out_v || nonempty));
            if (m_out_v) chk("payload", 64'(dut_pay()), 64'(m_pay));
        end
        @(posedge clk);
        if (!reset_n_i) begin
            m_valid = 1'b1; m_run = 1'b0; m_out_v = 1'b0; m_pay = '0;
            m_q.delete(); m_starve = 0;
        end else begin
            if (rl) begin
                m_out_v = 1'b1; m_pay = {1'b1, r_ent};
            end else if (pop) begin
                m_out_v = 1'b1; m_pay = {1'b0, m_q[0]};
            end else if (free) begin
                m_out_v = 1'b0;
            end
            if (pop || !nonempty) m_starve = 0;
            else if (rl && m_starve < LIM) m_starve++;
            if (pop) void'(m_q.pop_front());
            if (flush_i) m_q.delete();
            else if (commit_v_i && cr) m_q.push_back(c_ent);
            if (ltb_init_done_i) m_run = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_w_v"}, 64'(ltb_w_v_o), 64'd0);
        chk({tag, "_rr"}, 64'(redirect_ready_o), 64'd0);
        chk({tag, "_cr"}, 64'(commit_ready_o), 64'd0);
        chk({tag, "_cnt"}, 64'(queue_cnt_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_pay"}, 64'(dut_pay()), 64'd0);
    endtask

    int rv_pct;

    initial begin
        @(negedge clk);
        reset_n_i = 1'b0;
        cycle();
        cycle();
        reset_n_i = 1'b1;
        #1 chk_all_zero("reset");

        // No acceptance before init completes, even with both valids high.
        redirect_v_i = 1'b1; commit_v_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("wait_rr", 64'(redirect_ready_o), 64'd0);
            chk("wait_cr", 64'(commit_ready_o), 64'd0);
            chk("wait_w_v", 64'(ltb_w_v_o), 64'd0);
            cycle();
        end
        ltb_init_done_i = 1'b1;
        cycle();
        ltb_init_done_i = 1'b0; redirect_v_i = 1'b0; commit_v_i = 1'b0;
        #1;
        chk("init_rr", 64'(redirect_ready_o), 64'd1);
        chk("init_cr", 64'(commit_ready_o), 64'd1);
        cycle();

        // Single redirect lands one cycle later as a mispredict write.
        redirect_v_i = 1'b1; redirect_src_addr_i = 39'h1000; redirect_taken_i = 1'b0;
        ltb_w_yumi_i = 1'b1;
        cycle();
        redirect_v_i = 1'b0;
        #1;
        chk("redir_w_v", 64'(ltb_w_v_o), 64'd1);
        chk("redir_addr", 64'(ltb_br_src_addr_o), 64'h1000);
        chk("redir_mis", 64'(ltb_br_mispredict_o), 64'd1);
        cycle();

        // Fill: first commit occupies the output, four more fill the queue.
        ltb_w_yumi_i = 1'b0; commit_v_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            commit_src_addr_i = 39'h2000 + 39'(k);
            cycle();
        end
        #1;
        chk("full_cnt", 64'(queue_cnt_o), 64'd4);
        chk("full_cr", 64'(commit_ready_o), 64'd0);
        commit_v_i = 1'b0; ltb_w_yumi_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("drain_w_v", 64'(ltb_w_v_o), 64'd1);
            chk("drain_addr", 64'(ltb_br_src_addr_o), 64'h2000 + 64'(k));
            cycle();
        end

        // Starvation limit: 4 redirects, then one forced commit, then redirects.
        ltb_w_yumi_i = 1'b0; commit_v_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            commit_src_addr_i = 39'h3000 + 39'(k);
            cycle();
        end
        commit_v_i = 1'b0; redirect_v_i = 1'b1; ltb_w_yumi_i = 1'b1;
        for (int j = 0; j < 7; j++) begin
            redirect_src_addr_i = 39'h4000 + 39'(j);
            cycle();
            #1 chk("starve_mis", 64'(ltb_br_mispredict_o), (j == 4) ? 64'd0 : 64'd1);
        end
        redirect_v_i = 1'b0;
        repeat (3) cycle();

        // Flush with a same-cycle commit while the output is held.
        ltb_w_yumi_i = 1'b0; commit_v_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            commit_src_addr_i = 39'h5000 + 39'(k);
            cycle();
        end
        flush_i = 1'b1; commit_src_addr_i = 39'h5fff;
        cycle();
        flush_i = 1'b0; commit_v_i = 1'b0;
        #1;
        chk("flush_cnt", 64'(queue_cnt_o), 64'd0);
        chk("flush_w_v", 64'(ltb_w_v_o), 64'd1);
        chk("flush_addr", 64'(ltb_br_src_addr_o), 64'h5000);
        cycle();

        // Reset mid-operation with a full queue and a held write.
        commit_v_i = 1'b1;
        repeat (6) cycle();
        #1 chk("pre_rst_cnt", 64'(queue_cnt_o), 64'd4);
        reset_n_i = 1'b0; redirect_v_i = 1'b1;
        cycle();
        reset_n_i = 1'b1;
        #1 chk_all_zero("mid_reset");
        cycle();

        // Randomized traffic against the model.
        rv_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) rv_pct = (rv_pct == 90) ? 30 : 90;
            reset_n_i        = ($urandom_range(0, 399) != 0);
            ltb_init_done_i  = ($urandom_range(0, 3) == 0);
            redirect_v_i     = ($urandom_range(0, 99) < rv_pct);
            redirect_taken_i = 1'($urandom());
            redirect_conf_i  = 1'($urandom());
            redirect_src_addr_i = 39'({$urandom(), $urandom()});
            redirect_non_spec_cnt_i = 8'($urandom());
            redirect_trip_cnt_i     = 8'($urandom());
            commit_v_i       = ($urandom_range(0, 3) != 0);
            commit_taken_i   = 1'($urandom());
            commit_conf_i    = 1'($urandom());
            commit_src_addr_i = 39'({$urandom(), $urandom()});
            commit_non_spec_cnt_i = 8'($urandom());
            commit_trip_cnt_i     = 8'($urandom());
            flush_i          = ($urandom_range(0, 19) == 0);
            ltb_w_yumi_i     = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
